// File: rtl/wb_openram_bridge.sv
// wb_openram_bridge
// Wishbone classic responder that maps a configurable address window onto the
// 1rw port 0 of a single-port OpenRAM SRAM macro. Each single-beat access is
// turned into a one-cycle chip-select pulse, and the master is acked with a
// single-cycle pulse once the SRAM operation has completed.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock (rising edge), synchronous active-high reset
//   wbs_stb_i, wbs_cyc_i    Wishbone strobe / cycle
//   wbs_we_i, wbs_sel_i     write enable, byte selects
//   wbs_adr_i, wbs_dat_i    byte address, write data
//   wbs_ack_o, wbs_dat_o    registered ack pulse, registered read data
//   ram_csb0, ram_web0      SRAM chip select / write enable (active-low)
//   ram_wmask0              SRAM byte write mask
//   ram_addr0, ram_din0     SRAM word address / write data
//   ram_dout0               SRAM read data
//
// Optional build macro WB_OPENRAM_BRIDGE_STATS_EN adds saturating 16-bit
// counters stat_rd_cnt / stat_wr_cnt of acked in-window reads / writes.

module wb_openram_bridge #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              ram_csb0,
  output logic              ram_web0,
  output logic [3:0]        ram_wmask0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [31:0]       ram_din0,
  input  logic [31:0]       ram_dout0
`ifdef WB_OPENRAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StAccess, StRwait, StErr, StAck} state_e;

  localparam logic [1:0] LatInit = 2'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;

  logic req;
  logic in_win;

  // ack_q is always low in StIdle; kept in the term so a request can never be
  // taken while an ack is still visible to the master.
  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign in_win = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d = wbs_we_i;
          if (in_win) begin
            csb_d   = 1'b0;
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
            addr_d  = wbs_adr_i[ADDR_W+1:2];
            din_d   = wbs_dat_i;
            state_d = StAccess;
          end else begin
            state_d = StErr;
          end
        end
      end
      StAccess: begin
        // SRAM captures the operation on this edge; deselect afterwards.
        csb_d = 1'b1;
        web_d = 1'b1;
        if (we_q) begin
          if (wbs_cyc_i) begin
            ack_d   = 1'b1;
            state_d = StAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d   = LatInit;
          state_d = StRwait;
        end
      end
      StRwait: begin
        if (cnt_q == 2'd0) begin
          if (wbs_cyc_i) begin
            dat_d   = ram_dout0;
            ack_d   = 1'b1;
            state_d = StAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StErr: begin
        if (wbs_cyc_i) begin
          ack_d = 1'b1;
          if (!we_q) dat_d = ERR_DATA;
          state_d = StAck;
        end else begin
          state_d = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 4'h0;
      addr_q  <= '0;
      din_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign ram_csb0   = csb_q;
  assign ram_web0   = web_q;
  assign ram_wmask0 = wmask_q;
  assign ram_addr0  = addr_q;
  assign ram_din0   = din_q;

`ifdef WB_OPENRAM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        rd_done;
  logic        wr_done;

  // Count only accesses whose ack is actually registered.
  assign wr_done = (state_q == StAccess) & we_q & wbs_cyc_i;
  assign rd_done = (state_q == StRwait) & (cnt_q == 2'd0) & wbs_cyc_i;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_done && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_done && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_wr_cnt = wr_cnt_q;
`endif

endmodule
